// File: rtl/spmm_pkg.sv
// Shared SpMM types and sizes: tile dimension, element width and the
// index widths used by the CSR packet fields.
package spmm_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned W     = 8;
  localparam int unsigned lgN   = $clog2(N);
  localparam int unsigned dbLgN = lgN + 1;

  typedef logic [W-1:0] data_t;

  typedef enum logic {StFill, StSend} enc_state_e;

endpackage

// File: rtl/row_compactor.sv
// Combinational compaction of one dense row into consecutive CSR slots
// starting at base_i, using a prefix count over the nonzero mask.
module row_compactor
  import spmm_pkg::*;
(
  input  data_t [N-1:0]            row_i,
  input  logic  [dbLgN-1:0]        base_i,
  output logic  [dbLgN-1:0]        k_o,
  output logic  [N-1:0]            we_o,
  output data_t [N-1:0]            data_o,
  output logic  [N-1:0][lgN-1:0]   col_o
);

  localparam int unsigned PosW = dbLgN + 1;

  logic [N-1:0]             nz;
  logic [N-1:0][dbLgN-1:0]  pre;
  logic [dbLgN-1:0]         cnt;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      nz[j] = |row_i[j];
    end
  end

  // pre[j] = number of nonzeros strictly left of column j
  always_comb begin
    cnt = '0;
    for (int j = 0; j < N; j++) begin
      pre[j] = cnt;
      if (nz[j]) cnt = cnt + dbLgN'(1);
    end
  end

  assign k_o = cnt;

  always_comb begin
    we_o   = '0;
    data_o = '0;
    col_o  = '0;
    for (int s = 0; s < N; s++) begin
      for (int j = 0; j < N; j++) begin
        if (nz[j] && (({1'b0, base_i} + {1'b0, pre[j]}) == PosW'(s))) begin
          we_o[s]   = 1'b1;
          data_o[s] = row_i[j];
          col_o[s]  = lgN'(j);
        end
      end
    end
  end

endmodule

// File: rtl/csr_encoder.sv
// Dense-to-CSR encoder feeding the SpMM LHS port; tiles with more than N
// nonzeros are split into a first packet plus continuation packets.
module csr_encoder
  import spmm_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_ws,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  data_t [N-1:0]            row_data,
  input  logic                     lhs_ready,
  output logic                     lhs_start,
  output logic                     lhs_ws,
  output logic                     lhs_os,
  output logic  [N-1:0][dbLgN-1:0] lhs_ptr,
  output logic  [N-1:0][lgN-1:0]   lhs_col,
  output data_t [N-1:0]            lhs_data
);

  localparam int unsigned     SumW    = dbLgN + 1;
  localparam logic [lgN-1:0]  RowLast = lgN'(N - 1);
  localparam logic [SumW-1:0] Cap     = SumW'(N);

  enc_state_e               state_q, state_d;
  logic [lgN-1:0]           r_q, r_d;
  logic [dbLgN-1:0]         c_q, c_d;
  logic                     cont_q, cont_d;
  logic                     ws_q, ws_d;
  logic                     hold_vld_q, hold_vld_d;
  data_t [N-1:0]            hold_q, hold_d;
  logic [N-1:0][dbLgN-1:0]  ptr_q, ptr_d;
  logic [N-1:0][lgN-1:0]    col_q, col_d;
  data_t [N-1:0]            data_q, data_d;

  data_t [N-1:0]            cmp_row;
  logic [dbLgN-1:0]         cmp_base;
  logic [dbLgN-1:0]         cmp_k;
  logic [N-1:0]             cmp_we;
  data_t [N-1:0]            cmp_data;
  logic [N-1:0][lgN-1:0]    cmp_col;
  logic [SumW-1:0]          sum;

  // In SEND the compactor re-encodes the held row from slot 0 for the next packet
  assign cmp_row  = (state_q == StSend) ? hold_q : row_data;
  assign cmp_base = (state_q == StSend) ? '0 : c_q;
  assign sum      = {1'b0, c_q} + {1'b0, cmp_k};

  row_compactor u_row_compactor (
    .row_i  (cmp_row),
    .base_i (cmp_base),
    .k_o    (cmp_k),
    .we_o   (cmp_we),
    .data_o (cmp_data),
    .col_o  (cmp_col)
  );

  assign row_ready = (state_q == StFill) && !hold_vld_q;
  assign lhs_start = (state_q == StSend) && lhs_ready;
  assign lhs_ws    = ws_q;
  assign lhs_os    = cont_q;
  assign lhs_ptr   = ptr_q;
  assign lhs_col   = col_q;
  assign lhs_data  = data_q;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    cont_d     = cont_q;
    ws_d       = ws_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;
    col_d      = col_q;
    data_d     = data_q;

    unique case (state_q)
      StFill: begin
        if (row_valid && row_ready) begin
          if (r_q == '0 && !cont_q) ws_d = cfg_ws;
          if (sum <= Cap) begin
            for (int s = 0; s < N; s++) begin
              if (cmp_we[s]) begin
                data_d[s] = cmp_data[s];
                col_d[s]  = cmp_col[s];
              end
            end
            ptr_d[r_q] = sum[dbLgN-1:0];
            c_d        = sum[dbLgN-1:0];
            if (r_q == RowLast) state_d = StSend;
            else                r_d     = r_q + lgN'(1);
          end else begin
            // Overflow: close this packet at c and carry the row over
            for (int i = 0; i < N; i++) begin
              if (lgN'(i) >= r_q) ptr_d[i] = c_q;
            end
            hold_d     = row_data;
            hold_vld_d = 1'b1;
            state_d    = StSend;
          end
        end
      end
      StSend: begin
        if (lhs_ready) begin
          ptr_d  = '0;
          col_d  = '0;
          data_d = '0;
          c_d    = '0;
          if (hold_vld_q) begin
            for (int s = 0; s < N; s++) begin
              if (cmp_we[s]) begin
                data_d[s] = cmp_data[s];
                col_d[s]  = cmp_col[s];
              end
            end
            ptr_d[r_q] = cmp_k;
            c_d        = cmp_k;
            cont_d     = 1'b1;
            hold_vld_d = 1'b0;
            if (r_q != RowLast) begin
              r_d     = r_q + lgN'(1);
              state_d = StFill;
            end
          end else begin
            r_d     = '0;
            cont_d  = 1'b0;
            state_d = StFill;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StFill;
      r_q        <= '0;
      c_q        <= '0;
      cont_q     <= 1'b0;
      ws_q       <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      ptr_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      cont_q     <= cont_d;
      ws_q       <= ws_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      col_q      <= col_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_csr_encoder.sv
// Directed self-checking bench for csr_encoder.
module tb_csr_encoder;
  import spmm_pkg::*;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     cfg_ws;
  logic                     row_valid;
  logic                     row_ready;
  data_t [N-1:0]            row_data;
  logic                     lhs_ready;
  logic                     lhs_start;
  logic                     lhs_ws;
  logic                     lhs_os;
  logic [N-1:0][dbLgN-1:0]  lhs_ptr;
  logic [N-1:0][lgN-1:0]    lhs_col;
  data_t [N-1:0]            lhs_data;

  data_t [N-1:0] tile [N];
  int total = 0;
  int bad   = 0;

  csr_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_ws    (cfg_ws),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_ws    (lhs_ws),
    .lhs_os    (lhs_os),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data)
  );

  always #5 clock = ~clock;

  task automatic load_zero();
    for (int r = 0; r < N; r++) tile[r] = '0;
  endtask

  task automatic load_diag();
    load_zero();
    for (int r = 0; r < N; r++) tile[r][r] = data_t'(r + 1);
  endtask

  // Offer rows first..last in order, waiting (bounded) for row_ready on each.
  task automatic feed_rows(input int first, input int last, input logic ws);
    int budget;
    for (int r = first; r <= last; r++) begin
      row_valid = 1'b1;
      row_data  = tile[r];
      cfg_ws    = ws;
      budget    = 0;
      while (!row_ready && budget < 50) begin
        @(posedge clock); #1;
        budget++;
      end
      if (!row_ready) begin
        total++; bad++;
        $display("FAIL feed_timeout row=%0d row_ready=0 required=1", r);
      end
      @(posedge clock); #1;
    end
    row_valid = 1'b0;
  endtask

  task automatic pulse_ready(output logic seen, output logic after);
    lhs_ready = 1'b1;
    #1 seen = lhs_start;
    @(posedge clock); #1;
    after = lhs_start;
    lhs_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; row_valid = 1'b0; lhs_ready = 1'b1; cfg_ws = 1'b0; row_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    total++; if (row_ready !== 1'b1) begin bad++; $display("FAIL rst_row_ready got=%b exp=1", row_ready); end
    total++; if (lhs_start !== 1'b0) begin bad++; $display("FAIL rst_lhs_start got=%b exp=0", lhs_start); end
    total++; if (lhs_os !== 1'b0 || lhs_ws !== 1'b0) begin bad++; $display("FAIL rst_flags got os=%b ws=%b exp=0", lhs_os, lhs_ws); end
    total++; if (lhs_ptr !== '0 || lhs_col !== '0 || lhs_data !== '0) begin bad++; $display("FAIL rst_buffer got ptr=%h exp=0", lhs_ptr); end
    lhs_ready = 1'b0;
  endtask

  task automatic test_diagonal();
    logic seen, after;
    load_diag();
    feed_rows(0, N - 1, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++; if (lhs_ptr[i] !== dbLgN'(i + 1)) begin bad++; $display("FAIL diag_ptr[%0d] got=%0d exp=%0d", i, lhs_ptr[i], i + 1); end
      total++; if (lhs_col[i] !== lgN'(i)) begin bad++; $display("FAIL diag_col[%0d] got=%0d exp=%0d", i, lhs_col[i], i); end
      total++; if (lhs_data[i] !== data_t'(i + 1)) begin bad++; $display("FAIL diag_data[%0d] got=%0d exp=%0d", i, lhs_data[i], i + 1); end
    end
    total++; if (lhs_os !== 1'b0) begin bad++; $display("FAIL diag_os got=%b exp=0", lhs_os); end
    pulse_ready(seen, after);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL diag_start got=%b exp=1", seen); end
    total++; if (after !== 1'b0 || row_ready !== 1'b1) begin bad++; $display("FAIL diag_done got start=%b ready=%b exp 0/1", after, row_ready); end
  endtask

  task automatic test_all_zero();
    int n = 0;
    load_zero();
    feed_rows(0, N - 1, 1'b0);
    total++; if (lhs_ptr !== '0 || lhs_col !== '0 || lhs_data !== '0) begin bad++; $display("FAIL zero_buffer got ptr=%h data=%h exp=0", lhs_ptr, lhs_data); end
    total++; if (row_ready !== 1'b0) begin bad++; $display("FAIL zero_row_ready got=%b exp=0", row_ready); end
    lhs_ready = 1'b1;
    repeat (5) begin
      #1 if (lhs_start === 1'b1) n++;
      @(posedge clock);
    end
    #1 lhs_ready = 1'b0;
    total++; if (n != 1) begin bad++; $display("FAIL zero_start_count got=%0d exp=1", n); end
  endtask

  task automatic test_split();
    logic seen, after;
    load_zero();
    tile[0] = {N{data_t'(1)}};
    tile[1] = {N{data_t'(1)}};
    feed_rows(0, 1, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++; if (lhs_ptr[i] !== dbLgN'(N) || lhs_col[i] !== lgN'(i) || lhs_data[i] !== data_t'(1)) begin
        bad++; $display("FAIL split1_slot[%0d] got ptr=%0d col=%0d data=%0d exp %0d/%0d/1", i, lhs_ptr[i], lhs_col[i], lhs_data[i], N, i);
      end
    end
    total++; if (lhs_os !== 1'b0 || row_ready !== 1'b0) begin bad++; $display("FAIL split1_flags got os=%b ready=%b exp 0/0", lhs_os, row_ready); end
    pulse_ready(seen, after);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL split1_start got=%b exp=1", seen); end
    total++; if (row_ready !== 1'b1 || lhs_os !== 1'b1) begin bad++; $display("FAIL split_resume got ready=%b os=%b exp 1/1", row_ready, lhs_os); end
    feed_rows(2, N - 1, 1'b0);
    total++; if (lhs_ptr[0] !== '0) begin bad++; $display("FAIL split2_ptr[0] got=%0d exp=0", lhs_ptr[0]); end
    for (int i = 1; i < N; i++) begin
      total++; if (lhs_ptr[i] !== dbLgN'(N)) begin bad++; $display("FAIL split2_ptr[%0d] got=%0d exp=%0d", i, lhs_ptr[i], N); end
    end
    for (int i = 0; i < N; i++) begin
      total++; if (lhs_col[i] !== lgN'(i) || lhs_data[i] !== data_t'(1)) begin
        bad++; $display("FAIL split2_slot[%0d] got col=%0d data=%0d exp %0d/1", i, lhs_col[i], lhs_data[i], i);
      end
    end
    total++; if (lhs_os !== 1'b1) begin bad++; $display("FAIL split2_os got=%b exp=1", lhs_os); end
    pulse_ready(seen, after);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL split2_start got=%b exp=1", seen); end
    total++; if (lhs_os !== 1'b0 || row_ready !== 1'b1) begin bad++; $display("FAIL split_end got os=%b ready=%b exp 0/1", lhs_os, row_ready); end
  endtask

  task automatic test_backpressure();
    logic seen, after;
    logic [N-1:0][dbLgN-1:0] exp_ptr;
    data_t [N-1:0]           exp_data;
    logic [N-1:0][lgN-1:0]   exp_col;
    load_zero();
    for (int r = 0; r < N; r++) begin
      tile[r][N - 1 - r] = data_t'(8'h10 + r);
      exp_ptr[r]  = dbLgN'(r + 1);
      exp_col[r]  = lgN'(N - 1 - r);
      exp_data[r] = data_t'(8'h10 + r);
    end
    feed_rows(0, N - 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      total++; if (lhs_start !== 1'b0 || row_ready !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got start=%b ready=%b exp 0/0", k, lhs_start, row_ready); end
      total++; if (lhs_ptr !== exp_ptr || lhs_col !== exp_col || lhs_data !== exp_data) begin
        bad++; $display("FAIL bp_stable[%0d] got ptr=%h col=%h data=%h exp ptr=%h col=%h data=%h", k, lhs_ptr, lhs_col, lhs_data, exp_ptr, exp_col, exp_data);
      end
      @(posedge clock); #1;
    end
    total++; if (lhs_ws !== 1'b1) begin bad++; $display("FAIL bp_ws got=%b exp=1", lhs_ws); end
    pulse_ready(seen, after);
    total++; if (seen !== 1'b1 || after !== 1'b0) begin bad++; $display("FAIL bp_pulse got rise=%b next=%b exp 1/0", seen, after); end
  endtask

  task automatic test_reset_mid_tile();
    load_diag();
    lhs_ready = 1'b1;
    feed_rows(0, 6, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total++; if (row_ready !== 1'b1 || lhs_start !== 1'b0) begin bad++; $display("FAIL midrst_state got ready=%b start=%b exp 1/0", row_ready, lhs_start); end
    total++; if (lhs_ptr !== '0 || lhs_data !== '0) begin bad++; $display("FAIL midrst_buffer got ptr=%h exp=0", lhs_ptr); end
    feed_rows(0, N - 1, 1'b0);
    total++; if (lhs_start !== 1'b1) begin bad++; $display("FAIL midrst_latency got start=%b exp=1", lhs_start); end
    for (int i = 0; i < N; i++) begin
      total++; if (lhs_ptr[i] !== dbLgN'(i + 1) || lhs_col[i] !== lgN'(i) || lhs_data[i] !== data_t'(i + 1)) begin
        bad++; $display("FAIL midrst_slot[%0d] got ptr=%0d col=%0d data=%0d exp %0d/%0d/%0d", i, lhs_ptr[i], lhs_col[i], lhs_data[i], i + 1, i, i + 1);
      end
    end
    total++; if (lhs_os !== 1'b0) begin bad++; $display("FAIL midrst_os got=%b exp=0", lhs_os); end
    @(posedge clock); #1;
    total++; if (lhs_start !== 1'b0) begin bad++; $display("FAIL midrst_single got start=%b exp=0", lhs_start); end
    lhs_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx = 0, tl = 0, npk = 0, last = -1;
    logic acc;
    load_diag();
    lhs_ready = 1'b1;
    row_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (lhs_start === 1'b1) begin
        total++; if (lhs_ws !== ((npk % 2) == 0)) begin bad++; $display("FAIL b2b_ws[%0d] got=%b exp=%b", npk, lhs_ws, (npk % 2) == 0); end
        total++; if (lhs_ptr[N-1] !== dbLgN'(N)) begin bad++; $display("FAIL b2b_ptr[%0d] got=%0d exp=%0d", npk, lhs_ptr[N-1], N); end
        if (last >= 0) begin
          total++; if (cyc - last != 17) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=17", npk, cyc - last); end
        end
        last = cyc;
        npk++;
      end
      acc       = row_ready;
      row_data  = tile[idx];
      cfg_ws    = ((tl % 2) == 0);
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        if (idx == N) begin idx = 0; tl++; end
      end
    end
    row_valid = 1'b0;
    lhs_ready = 1'b0;
    total++; if (npk != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", npk); end
  endtask

  initial begin
    test_reset();
    test_diagonal();
    test_all_zero();
    test_split();
    test_backpressure();
    test_reset_mid_tile();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_encoder.md
# csr_encoder

Producer-side front end for the SpMM LHS port. Accepts a dense N×N LHS tile one row per cycle, compacts the nonzeros into CSR packets (`lhs_ptr`/`lhs_col`/`lhs_data`, at most N nonzeros per packet), and issues each packet to the SpMM with `lhs_start`. When a tile holds more than N nonzeros, it is split across several packets. Every continuation packet carries `lhs_os`=1, so the SpMM accumulates the partial results into the same output.

## Interface
Parameters:
- `N`, 16: tile dimension and packet nonzero capacity.
- `W`, 8: element width (`data_t`).

Ports:
- Clocking: one clock (`clock`); synchronous, active-high reset (`reset`). These are fixed.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_ws`  in  1  weight-stationary flag, sampled at the first row of each tile.
- `row_valid`  in  1  `row_data` holds the next dense row.
- `row_ready`  out  1  encoder can accept a row this cycle.
- `row_data`  in  data_t[N]  dense row; `row_data[c]` is column c.
- `lhs_ready`  in  1  SpMM LHS port ready (`lhs_ready_ns`/`_ws`/`_os`/`_wos`, selected upstream).
- `lhs_start`  out  1  packet transfer strobe.
- `lhs_ws`  out  1  latched `cfg_ws` of the current tile.
- `lhs_os`  out  1  packet is a continuation of the current tile.
- `lhs_ptr`  out  [dbLgN-1:0][N]  exclusive end index of each row's nonzeros.
- `lhs_col`  out  [lgN-1:0][N]  column of each slot.
- `lhs_data`  out  data_t[N]  value of each slot.

## Operation
- Internal state:
  - FSM states FILL and SEND.
  - Row counter `r` (0..N-1).
  - Slot count `c` (0..N).
  - Continuation flag `cont`.
  - Hold register `hold` with a valid bit, plus the packet buffer.
- Row acceptance:
  - Accept = `row_valid` && `row_ready`.
  - Let `k` = number of nonzero elements in the row.
  - Row rows arrive in tile order 0..N-1.
- FILL, accepted row with `c+k ≤ N`:
  - Write the nonzeros, in ascending column order, to slots c..c+k-1.
  - Set `ptr[r]` = c+k, then `c` += k.
  - If `r`==N-1, go to SEND. Otherwise `r`++.
- FILL, accepted row with `c+k > N` (overflow):
  - Set `ptr[r..N-1]` = c.
  - Copy the row into `hold` and go to SEND.
- SEND:
  - Buffer and outputs are frozen.
  - On handshake, the buffer clears: data=0, col=0, ptr=0, `c`=0.
- After a handshake with `hold` valid:
  - Insert the held row at row `r` on the same edge; it always fits since k ≤ N.
  - Set `cont`=1.
  - If `r`==N-1, stay in SEND. Otherwise `r`++ and go to FILL.
- After a handshake with no hold:
  - Set `r`=0, `cont`=0, go to FILL; the tile is done.
- In continuation packets, rows before the split row have `ptr`=0.
- Unused slots read data=0, col=0.
- An all-zero tile still emits one packet with all `ptr`=0.
- Output flags:
  - `lhs_os` = `cont` of the packet being sent.
  - `lhs_ws` is constant for all packets of a tile.

## Timing
- `row_ready` = (state==FILL) && !`hold`.valid.
- `lhs_start` = (state==SEND) && `lhs_ready`. This is combinational; the handshake completes in that cycle and `lhs_start` is high for exactly one cycle per packet.
- Latency: last row accepted at edge t → packet valid from cycle t+1. `lhs_start` asserts at t+1 if `lhs_ready`=1.
- Throughput: a tile with ≤N nonzeros takes N+1 cycles under full handshake. Each split adds one cycle.
- `lhs_*` are held stable throughout SEND, regardless of `lhs_ready`.
- Reset values:
  - `row_ready`=1 from the first cycle after reset.
  - `lhs_start`=0, `lhs_os`=0, `lhs_ws`=0.
  - `lhs_ptr`/`lhs_col`/`lhs_data`=0.
  - State FILL, r=0, c=0, `hold` invalid.
- Reset mid-tile or during SEND discards the partial tile; no packet is emitted.

## Structure
- Shared package `spmm_pkg`: `N`, `W`, `lgN`, `dbLgN`, `data_t`.
- Sub-module `row_compactor` (combinational):
  - Input: row and base slot `c`.
  - Output: `k`, per-slot write enables, data, and columns.
  - Uses prefix counts over the nonzero mask.
- Top level: FSM, counters, hold register and packet buffer.

## Test plan
- Diagonal tile (N=16), row i = value i+1 at column i → one packet: `ptr[i]`=i+1, `col[i]`=i, `data[i]`=i+1, `lhs_os`=0.
- All-zero tile → one packet, all `ptr`/`col`/`data`=0, exactly one `lhs_start`.
- Rows 0 and 1 fully dense (all 1s), rest zero:
  - Packet 1: `ptr[0..15]`=16, `col`=0..15, `lhs_os`=0.
  - Packet 2: `ptr[0]`=0, `ptr[1..15]`=16, `lhs_os`=1.
- Backpressure: `lhs_ready`=0 for 10 cycles after the last row → `lhs_start`=0, outputs stable, `row_ready`=0. Then a single `lhs_start` pulse in the cycle `lhs_ready` rises.
- Reset after 7 rows accepted → next cycle `row_ready`=1, no `lhs_start`. The next full diagonal tile encodes as in the first scenario.
- Back-to-back tiles, `row_valid` always 1, `lhs_ready` always 1, `cfg_ws` toggling per tile → `lhs_start` every 17 cycles; `lhs_ws` matches each tile's first-row `cfg_ws`.
